line_delay_buffer: RTL
======================

// Module: line_delay_buffer
// PURPOSE
//  Parametrised, run-time-configurable sample delay line for CNN line buffering.
//  Replaces the fixed per-layer shift-register FIFOs between the input fetch and
//  the PE array. Adds valid-qualified (bubble-tolerant) shifting, selectable
//  depth, flush, and fill status.
//  Implemented as a ring buffer plus a registered output, not a register chain.
// PARAMETERS
//  DATA_W    128                     width of one sample (packed weights/pixels)
//  MAX_DEPTH 32                      max delay in accepted samples (>=1)
//  DEPTH_W   $clog2(MAX_DEPTH+1)     width of depth/fill fields
// PORTS
//  clk         in   1        clock; all state on rising edge
//  rst         in   1        async reset, ACTIVE-LOW (asserted at 0); async assert, sync release
//  flush       in   1        sync clear of occupancy; loads depth_cfg
//  depth_cfg   in   DEPTH_W  requested delay D; sampled only at flush
//  in_valid    in   1        in_data accepted this cycle
//  in_data     in   DATA_W   input sample
//  out_valid   out  1        out_data holds a delayed sample (1-cycle pulse per accept)
//  out_data    out  DATA_W   sample accepted D accepts before the current one
//  fill_count  out  DEPTH_W  samples held, saturates at D
//  primed      out  1        fill_count == D
// BEHAVIOUR
//  Reset (rst=0):
//   - out_valid=0, out_data=0, fill_count=0, wr_ptr=0, depth_q=MAX_DEPTH.
//   - primed=0 (D!=0). RAM contents are not reset.
//  Depth register:
//   - On a flush edge, depth_q <= min(depth_cfg, MAX_DEPTH); clamped, never an error.
//   - depth_cfg is ignored on all other cycles.
//  Accept:
//   - An accept is an edge with in_valid=1 and flush=0. Non-accept cycles hold all
//     state except out_valid, which drops to 0.
//  D>0, accept edge:
//   - out_valid <= (fill_count==D); out_data <= mem[wr_ptr] (oldest) if fill_count==D,
//     else holds.
//   - mem[wr_ptr] <= in_data (read-before-write, same entry).
//   - wr_ptr <= (wr_ptr==D-1) ? 0 : wr_ptr+1 (wrap at D-1, not MAX_DEPTH-1).
//   - fill_count <= min(fill_count+1, D).
//  D=0:
//   - Pure 1-register pipe: out_data <= in_data, out_valid <= 1 on each accept.
//   - fill_count stays 0; primed=1.
//  Latency:
//   - First out_valid on the edge of accept D+1, carrying sample 1.
//   - Steady state: one output per accept, regardless of bubble spacing.
//  Flush edge:
//   - fill_count<=0, wr_ptr<=0, out_valid<=0; out_data holds.
//   - Flush with in_valid=1 in the same cycle: flush wins, the sample is dropped.
//  primed: combinational from fill_count and depth_q.
//  Reset mid-stream: outputs clear immediately (async); depth_q returns to MAX_DEPTH.
//  No backpressure: the consumer must take every out_valid pulse.
// TESTING
//  1. rst=0 mid-stream -> same-cycle out_valid=0, out_data=0, fill_count=0;
//     after release depth_q=32.
//  2. flush D=4, stream 1..10 back-to-back -> out_valid first at accept 5 with out_data=1,
//     then 2..6; fill_count 1,2,3,4,4...
//  3. D=4, samples 1..8 with random in_valid bubbles -> outputs 1..4 in order,
//     one pulse per accept, none in bubbles.
//  4. D=3, send 1..5, flush with in_valid=1 (sample 99), send 6..9 -> 99 never appears;
//     first post-flush output is 6 on accept of 9.
//  5. flush depth_cfg=0 -> out_data=in_data one cycle later, primed=1;
//     depth_cfg=40 -> D clamps to 32, first output at accept 33.
//  6. D=5, 20 accepts -> wr_ptr wraps 4->0; output sequence equals input delayed by 5 accepts.

Source files
------------

// File: rtl/line_delay_buffer.sv
// line_delay_buffer
//   Run-time configurable sample delay line. Each accepted sample comes back out
//   D accepts later. Storage is a ring buffer with a registered output, so the
//   output only moves on accepts and bubbles cost nothing.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst        asynchronous reset, active low
//   flush      synchronous clear of occupancy; loads depth_cfg into the depth register
//   depth_cfg  requested delay D, sampled only on a flush edge (clamped to MAX_DEPTH)
//   in_valid   in_data is accepted this cycle (ignored when flush is high)
//   in_data    input sample
//   out_valid  one-cycle pulse: out_data holds a newly delayed sample
//   out_data   sample accepted D accepts before the one that produced this pulse
//   fill_count samples held, saturates at D
//   primed     fill_count == D
module line_delay_buffer #(
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned MAX_DEPTH = 32,
  parameter int unsigned DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [DEPTH_W-1:0] depth_cfg,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic [DEPTH_W-1:0] fill_count,
  output logic               primed
);

  localparam int unsigned PTR_W = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  localparam logic [DEPTH_W-1:0] MaxDepthW = DEPTH_W'(MAX_DEPTH);

  logic [DATA_W-1:0]  mem [MAX_DEPTH];

  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [DEPTH_W-1:0] fill_q, fill_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               mem_we;

  logic [DEPTH_W-1:0] depth_clamped;
  logic               depth_zero;
  logic               full;
  logic               ptr_last;

  assign depth_clamped = (depth_cfg > MaxDepthW) ? MaxDepthW : depth_cfg;
  assign depth_zero    = (depth_q == '0);
  assign full          = (fill_q == depth_q);
  // Wrap at the configured depth, not at the physical size of the RAM.
  assign ptr_last      = (DEPTH_W'(wr_ptr_q) == (depth_q - DEPTH_W'(1)));

  always_comb begin
    depth_d     = depth_q;
    fill_d      = fill_q;
    wr_ptr_d    = wr_ptr_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    mem_we      = 1'b0;
    if (flush) begin
      // Flush wins over a simultaneous in_valid; that sample is dropped.
      depth_d  = depth_clamped;
      fill_d   = '0;
      wr_ptr_d = '0;
    end else if (in_valid) begin
      if (depth_zero) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
      end else begin
        mem_we = 1'b1;
        if (full) begin
          // Slot about to be overwritten holds the oldest sample.
          out_valid_d = 1'b1;
          out_data_d  = mem[wr_ptr_q];
        end else begin
          fill_d = fill_q + DEPTH_W'(1);
        end
        wr_ptr_d = ptr_last ? '0 : wr_ptr_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      depth_q     <= MaxDepthW;
      fill_q      <= '0;
      wr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      depth_q     <= depth_d;
      fill_q      <= fill_d;
      wr_ptr_q    <= wr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign fill_count = fill_q;
  assign primed     = (fill_q == depth_q);

endmodule
